image_rom_reader: RTL and testbench

//  Read-side master for the 12-bit RGB image BRAM (19-bit address, registered output).
//  On start it walks a rectangular sprite window (base, width, height, stride) and

---
 rtl/image_pkg.sv | 28 ++
 rtl/pixel_skid_fifo.sv | 63 ++++++
 rtl/image_rom_reader.sv | 216 +++++++++++++++++++++
 tb/tb_image_rom_reader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
`default_nettype none
// ============================================================================
// Module : image_pkg
// Brief  : Shared constants, FSM encoding and pixel-beat layout for the image
//          BRAM read path.
// Rev    : 1.0  initial release
// ============================================================================
package image_pkg;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 12;
    localparam int DIM_W  = 10;
    localparam logic [PIX_W-1:0] KEY_COLOR = 12'hF0F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic             last;
        logic             transp;
        logic [PIX_W-1:0] data;
    } pix_beat_t;

endpackage
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module : pixel_skid_fifo
// Brief  : Small circular FIFO absorbing BRAM returns under output backpressure;
//          exposes its occupancy so the reader can meter its requests.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_skid_fifo
    import image_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 14
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_rd;

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rd    = rd_en && (r_count != '0);
    assign rd_data = r_mem[r_rd_ptr];
    assign valid   = (r_count != '0);
    assign count   = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= f_next(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            r_count <= r_count + c_cnt_w'(wr_en) - c_cnt_w'(w_rd);
        end
    end

endmodule
`default_nettype wire

// File: rtl/image_rom_reader.sv
`default_nettype none
// ============================================================================
// Module : image_rom_reader
// Brief  : Walks a sprite window in image BRAM and streams pixels on valid/ready.
//          Optional macro TRANSPARENT_KEY_EN adds the key-colour flag.
// Rev    : 1.0  initial release
// ============================================================================
module image_rom_reader
    import image_pkg::*;
#(
    parameter int ADDR_W = image_pkg::ADDR_W,
    parameter int PIX_W  = image_pkg::PIX_W,
    parameter int DIM_W  = image_pkg::DIM_W,
    parameter int RD_LAT = 1
`ifdef TRANSPARENT_KEY_EN
    ,
    parameter logic [PIX_W-1:0] KEY_COLOR = image_pkg::KEY_COLOR
`endif
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  stride,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_dout,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_last,
    output logic              pix_transp
);

    localparam int c_depth = RD_LAT + 1;
    localparam int c_cnt_w = $clog2(c_depth + 1);
    localparam int c_sum_w = c_cnt_w + 1;

    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_load;
    logic               w_rom_en;
    logic               w_col_end;
    logic               w_last_addr;
    logic               w_pop;
    logic               w_credit_ok;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  w_next_row;
    logic [DIM_W-1:0]   r_width;
    logic [DIM_W-1:0]   r_height;
    logic [DIM_W-1:0]   r_stride;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [RD_LAT-1:0]  r_sr_vld;
    logic [RD_LAT-1:0]  r_sr_last;
    logic [c_cnt_w-1:0] w_fifo_cnt;
    logic               w_fifo_valid;
    logic [c_sum_w-1:0] w_outstanding;
    logic [c_sum_w-1:0] w_used;

    // A pop in this cycle frees its slot immediately, which keeps 1 pixel/clk.
    always_comb begin
        w_outstanding = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_outstanding = w_outstanding + c_sum_w'(r_sr_vld[i]);
        end
    end

    assign w_pop       = w_fifo_valid & pix_ready;
    assign w_used      = w_outstanding + c_sum_w'(w_fifo_cnt) - c_sum_w'(w_pop);
    assign w_credit_ok = (w_used < c_sum_w'(c_depth));

    assign w_col_end   = (r_col == r_width - DIM_W'(1));
    assign w_last_addr = w_col_end && (r_row == r_height - DIM_W'(1));
    assign w_next_row  = r_row_base + ADDR_W'(r_stride);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_rom_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((width != '0) && (height != '0)) begin
                        w_load      = 1'b1;
                        w_state_nxt = FETCH;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (w_credit_ok) begin
                    w_rom_en = 1'b1;
                    if (w_last_addr) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_pop && pix_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_row_base <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_stride   <= '0;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_load) begin
            r_addr     <= base_addr;
            r_row_base <= base_addr;
            r_width    <= width;
            r_height   <= height;
            r_stride   <= stride;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_rom_en) begin
            if (w_col_end) begin
                r_col      <= '0;
                r_row      <= r_row + DIM_W'(1);
                r_row_base <= w_next_row;
                r_addr     <= w_next_row;
            end else begin
                r_col  <= r_col + DIM_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    // Tags travel alongside the BRAM pipeline so each return knows it is real
    // and whether it is the final pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_vld  <= '0;
            r_sr_last <= '0;
        end else begin
            r_sr_vld  <= (r_sr_vld << 1)  | RD_LAT'(w_rom_en);
            r_sr_last <= (r_sr_last << 1) | RD_LAT'(w_rom_en & w_last_addr);
        end
    end

`ifdef TRANSPARENT_KEY_EN
    localparam int c_beat_w = $bits(pix_beat_t);
    pix_beat_t w_wr_beat;
    pix_beat_t w_rd_beat;

    always_comb begin
        w_wr_beat.last   = r_sr_last[RD_LAT-1];
        w_wr_beat.transp = (rom_dout == KEY_COLOR);
        w_wr_beat.data   = rom_dout;
    end

    assign pix_data   = w_rd_beat.data;
    assign pix_last   = w_fifo_valid & w_rd_beat.last;
    assign pix_transp = w_fifo_valid & w_rd_beat.transp;
`else
    localparam int c_beat_w = PIX_W + 1;
    logic [c_beat_w-1:0] w_wr_beat;
    logic [c_beat_w-1:0] w_rd_beat;

    assign w_wr_beat  = {r_sr_last[RD_LAT-1], rom_dout};
    assign pix_data   = w_rd_beat[PIX_W-1:0];
    assign pix_last   = w_fifo_valid & w_rd_beat[PIX_W];
    assign pix_transp = 1'b0;
`endif

    pixel_skid_fifo #(
        .DEPTH (c_depth),
        .WIDTH (c_beat_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_sr_vld[RD_LAT-1]),
        .wr_data (w_wr_beat),
        .rd_en   (w_pop),
        .rd_data (w_rd_beat),
        .valid   (w_fifo_valid),
        .count   (w_fifo_cnt)
    );

    assign pix_valid = w_fifo_valid;
    assign rom_en    = w_rom_en;
    assign rom_addr  = r_addr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_image_rom_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_image_rom_reader
// Brief  : Scoreboard bench for image_rom_reader with a BRAM model rom[a]=a[11:0].
// Rev    : 1.0  initial release
// ============================================================================
module tb_image_rom_reader;

    localparam int ADDR_W = 19;
    localparam int PIX_W  = 12;
    localparam int DIM_W  = 10;
    localparam int MEMSZ  = 524288;

    typedef struct {
        logic [PIX_W-1:0] data;
        logic             last;
        logic             transp;
    } exp_pix_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [DIM_W-1:0]  stride;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_dout = '0;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_last;
    logic              pix_transp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    image_rom_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .width      (width),
        .height     (height),
        .stride     (stride),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_transp (pix_transp)
    );

    // Behavioural BRAM with one cycle of registered latency
    logic [ADDR_W-1:0] key_addr = '0;
    logic              key_on   = 1'b0;

    function automatic logic [PIX_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        if (key_on && a == key_addr) return 12'hF0F;
        return a[PIX_W-1:0];
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_dout <= rom_word(rom_addr);
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: window expressed directly as row/column arithmetic
    logic [ADDR_W-1:0] exp_addr_q[$];
    exp_pix_t          exp_pix_q[$];

    task automatic push_window(input int b, input int w, input int h, input int s);
        int n;
        int k;
        exp_pix_t e;
        logic [ADDR_W-1:0] a;
        n = w * h;
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                a = ADDR_W'((b + r * s + c) % MEMSZ);
                exp_addr_q.push_back(a);
                e.data = rom_word(a);
                e.last = (k == n - 1);
`ifdef TRANSPARENT_KEY_EN
                e.transp = (e.data == 12'hF0F);
`else
                e.transp = 1'b0;
`endif
                exp_pix_q.push_back(e);
                k++;
            end
        end
    endtask

    // Downstream ready pattern: 0 held high, 1 toggling, 2 random
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor / scoreboard
    int   cyc = 0;
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   issued = 0;
    int   accepted = 0;
    int   acc_win = 0;
    int   start_cyc = 0;
    int   first_valid_cyc = -1;
    int   first_acc_cyc = -1;
    int   last_acc_cyc = -1;
    bit   prev_stall = 1'b0;
    logic [PIX_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(negedge clk) begin
        bit nb;
        bit nd;
        bit acc;
        exp_pix_t e;
        logic [ADDR_W-1:0] ea;
        cyc++;
        if (rst) begin
            exp_addr_q.delete();
            exp_pix_q.delete();
            m_busy = 1'b0;
            m_done = 1'b0;
            issued = 0;
            accepted = 0;
            prev_stall = 1'b0;
        end else begin
            chk(busy === m_busy, "busy", longint'(busy), longint'(m_busy));
            chk(done === m_done, "done", longint'(done), longint'(m_done));
            nb = m_busy;
            nd = 1'b0;
            if (start && !m_busy) begin
                if (width == '0 || height == '0) nd = 1'b1;
                else begin
                    nb = 1'b1;
                    start_cyc = cyc;
                    first_valid_cyc = -1;
                    first_acc_cyc = -1;
                    acc_win = 0;
                end
            end
            acc = pix_valid && pix_ready;
            if (prev_stall)
                chk(pix_valid && pix_data == prev_data && pix_last == prev_last,
                    "stall_hold", longint'(pix_data), longint'(prev_data));
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rom_en) begin
                if (exp_addr_q.size() == 0) chk(1'b0, "rom_en_spurious", longint'(rom_addr), 0);
                else begin
                    ea = exp_addr_q.pop_front();
                    chk(rom_addr == ea, "rom_addr", longint'(rom_addr), longint'(ea));
                end
                chk(issued - accepted - int'(acc) < 2, "credit", issued - accepted - int'(acc), 1);
                issued++;
            end
            if (acc) begin
                if (exp_pix_q.size() == 0) chk(1'b0, "pix_spurious", longint'(pix_data), 0);
                else begin
                    e = exp_pix_q.pop_front();
                    chk(pix_data == e.data, "pix_data", longint'(pix_data), longint'(e.data));
                    chk(pix_last == e.last, "pix_last", longint'(pix_last), longint'(e.last));
                    chk(pix_transp == e.transp, "pix_transp", longint'(pix_transp), longint'(e.transp));
                    if (e.last) begin
                        nb = 1'b0;
                        nd = 1'b1;
                        last_acc_cyc = cyc;
                    end
                end
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                accepted++;
                acc_win++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            m_busy = nb;
            m_done = nd;
        end
    end

    task automatic issue_start(input int b, input int w, input int h, input int s, input bit model);
        @(posedge clk); #1;
        base_addr = ADDR_W'(b);
        width     = DIM_W'(w);
        height    = DIM_W'(h);
        stride    = DIM_W'(s);
        start     = 1'b1;
        if (model && w != 0 && h != 0) push_window(b, w, h, s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(done === 1'b1, {name, "_done_seen"}, longint'(done), 1);
        @(negedge clk); #1;
        chk(exp_pix_q.size() == 0 && exp_addr_q.size() == 0, {name, "_drained"},
            exp_pix_q.size() + exp_addr_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        chk(busy == 1'b0,       {name, "_busy"},   longint'(busy), 0);
        chk(done == 1'b0,       {name, "_done"},   longint'(done), 0);
        chk(rom_en == 1'b0,     {name, "_rom_en"}, longint'(rom_en), 0);
        chk(rom_addr == '0,     {name, "_rom_addr"}, longint'(rom_addr), 0);
        chk(pix_valid == 1'b0,  {name, "_valid"},  longint'(pix_valid), 0);
        chk(pix_data == '0,     {name, "_data"},   longint'(pix_data), 0);
        chk(pix_last == 1'b0,   {name, "_last"},   longint'(pix_last), 0);
        chk(pix_transp == 1'b0, {name, "_transp"}, longint'(pix_transp), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        width = '0;
        height = '0;
        stride = '0;
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // 1: basic window, full throughput
        ready_mode = 0;
        issue_start(262240, 4, 3, 320, 1'b1);
        wait_done("t1", 300);
        chk(last_acc_cyc - first_acc_cyc == 11, "t1_rate", last_acc_cyc - first_acc_cyc, 11);
        chk(first_valid_cyc - start_cyc == 3, "t1_latency", first_valid_cyc - start_cyc, 3);

        // 2: toggling ready, plus a start while busy that must be ignored
        ready_mode = 1;
        issue_start(262240, 4, 3, 320, 1'b1);
        issue_start(5000, 7, 7, 1, 1'b0);
        wait_done("t2", 300);

        // 3: degenerate window
        ready_mode = 0;
        issue_start(1234, 0, 5, 10, 1'b1);
        wait_done("t3", 20);

        // 4: address wrap at top of memory
        issue_start(524286, 4, 1, 0, 1'b1);
        wait_done("t4", 100);

        // 5: reset in the middle of a window, then a fresh window
        issue_start(256, 4, 3, 64, 1'b1);
        n = 0;
        while (acc_win < 5 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk(acc_win >= 5, "t5_reach5", acc_win, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_zero("t5_abort");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue_start(512, 2, 1, 0, 1'b1);
        wait_done("t5_restart", 100);

        // 6: key colour at the window origin
        ready_mode = 2;
        key_addr = ADDR_W'(4096);
        key_on = 1'b1;
        issue_start(4096, 4, 2, 16, 1'b1);
        wait_done("t6", 300);
        key_on = 1'b0;

        // 7: random windows under random backpressure
        for (int i = 0; i < 8; i++) begin
            issue_start(int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(1, 6)),
                        int'($urandom_range(1, 4)), int'($urandom_range(0, 1023)), 1'b1);
            wait_done("t7", 400);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
